mem_wb_pipe: RTL and testbench

//   Parametrised MEM->WB pipeline register that replaces the fixed single-lane latch.

---
 rtl/mem_wb_pipe.sv | 138 +++++++++++++
 tb/tb_mem_wb_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register: LANES write-back slots moved as one bundle behind a
// valid/ready handshake, with a one-entry skid so WB back-pressure never loses data.
module mem_wb_pipe #(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 5,
  parameter int LANES           = 1,
  parameter int ZERO_REG_SQUASH = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [LANES*DATA_W-1:0]   mem_wdata,
  input  logic [LANES*ADDR_W-1:0]   mem_wd,
  input  logic [LANES-1:0]          mem_wreg,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [LANES*DATA_W-1:0]   wb_wdata,
  output logic [LANES*ADDR_W-1:0]   wb_wd,
  output logic [LANES-1:0]          wb_wreg,
  output logic                      skid_full
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [LANES*DATA_W-1:0]   out_wdata_q, out_wdata_d;
  logic [LANES*ADDR_W-1:0]   out_wd_q, out_wd_d;
  logic [LANES-1:0]          out_wreg_q, out_wreg_d;
  logic [LANES*DATA_W-1:0]   skid_wdata_q, skid_wdata_d;
  logic [LANES*ADDR_W-1:0]   skid_wd_q, skid_wd_d;
  logic [LANES-1:0]          skid_wreg_q, skid_wreg_d;

  logic                      accept;
  logic                      retire;
  logic [LANES-1:0]          in_wreg;

  // A lane targeting r0 is kept but can never write when squashing is enabled.
  function automatic logic [LANES-1:0] squash_wreg(
    input logic [LANES*ADDR_W-1:0] wd,
    input logic [LANES-1:0]        wreg
  );
    logic [LANES-1:0] res;
    res = wreg;
    for (int i = 0; i < LANES; i++) begin
      if ((ZERO_REG_SQUASH != 0) && (wd[i*ADDR_W +: ADDR_W] == '0)) begin
        res[i] = 1'b0;
      end
    end
    return res;
  endfunction

  always_comb begin
    in_wreg   = squash_wreg(mem_wd, mem_wreg);
    wb_valid  = (state_q != ST_EMPTY);
    skid_full = (state_q == ST_FULL);
    mem_ready = (state_q != ST_FULL);
    accept    = mem_valid & mem_ready;
    retire    = wb_valid & wb_ready;
    wb_wdata  = out_wdata_q;
    wb_wd     = out_wd_q;
    wb_wreg   = out_wreg_q & {LANES{wb_valid}};
  end

  always_comb begin
    state_d      = state_q;
    out_wdata_d  = out_wdata_q;
    out_wd_d     = out_wd_q;
    out_wreg_d   = out_wreg_q;
    skid_wdata_d = skid_wdata_q;
    skid_wd_d    = skid_wd_q;
    skid_wreg_d  = skid_wreg_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_ONE;
            out_wdata_d = mem_wdata;
            out_wd_d    = mem_wd;
            out_wreg_d  = in_wreg;
          end
        end
        ST_ONE: begin
          if (accept && retire) begin
            out_wdata_d = mem_wdata;
            out_wd_d    = mem_wd;
            out_wreg_d  = in_wreg;
          end else if (accept) begin
            // OUT still holds the older bundle; the newcomer waits behind it.
            state_d      = ST_FULL;
            skid_wdata_d = mem_wdata;
            skid_wd_d    = mem_wd;
            skid_wreg_d  = in_wreg;
          end else if (retire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (retire) begin
            state_d     = ST_ONE;
            out_wdata_d = skid_wdata_q;
            out_wd_d    = skid_wd_q;
            out_wreg_d  = skid_wreg_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      out_wdata_q  <= '0;
      out_wd_q     <= '0;
      out_wreg_q   <= '0;
      skid_wdata_q <= '0;
      skid_wd_q    <= '0;
      skid_wreg_q  <= '0;
    end else begin
      state_q      <= state_d;
      out_wdata_q  <= out_wdata_d;
      out_wd_q     <= out_wd_d;
      out_wreg_q   <= out_wreg_d;
      skid_wdata_q <= skid_wdata_d;
      skid_wd_q    <= skid_wd_d;
      skid_wreg_q  <= skid_wreg_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: two-lane instances with and without r0 squashing, checked
// each cycle against a queue-based model plus hand-computed directed expectations.
`timescale 1ns/1ps
module tb_mem_wb_pipe;

  typedef struct packed {
    logic [63:0] wdata;
    logic [9:0]  wd;
    logic [1:0]  wreg;
  } bun_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        mem_valid;
  logic [63:0] mem_wdata;
  logic [9:0]  mem_wd;
  logic [1:0]  mem_wreg;
  logic        wb_ready;

  logic        mem_ready, wb_valid, skid_full;
  logic [63:0] wb_wdata;
  logic [9:0]  wb_wd;
  logic [1:0]  wb_wreg;
  logic        mem_ready_n, wb_valid_n, skid_full_n;
  logic [63:0] wb_wdata_n;
  logic [9:0]  wb_wd_n;
  logic [1:0]  wb_wreg_n;

  int n_cmp = 0;
  int n_bad = 0;

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .LANES(2), .ZERO_REG_SQUASH(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wdata(wb_wdata), .wb_wd(wb_wd),
    .wb_wreg(wb_wreg), .skid_full(skid_full)
  );

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .LANES(2), .ZERO_REG_SQUASH(0)) dut_n (
    .clk(clk), .rst(rst), .flush(flush), .mem_valid(mem_valid), .mem_ready(mem_ready_n),
    .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .wb_valid(wb_valid_n), .wb_ready(wb_ready), .wb_wdata(wb_wdata_n), .wb_wd(wb_wd_n),
    .wb_wreg(wb_wreg_n), .skid_full(skid_full_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_wreg(input bun_t b, input bit squash);
    logic [1:0] r;
    for (int i = 0; i < 2; i++) begin
      r[i] = b.wreg[i] && !(squash && (b.wd[i*5 +: 5] == 5'd0));
    end
    return r;
  endfunction

  // Model: the stage is a FIFO of at most two bundles in acceptance order.
  bun_t q[$];
  bit   zero_known = 1'b1;
  bit   m_acc, m_ret, exp_v;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      zero_known = 1'b1;
    end else begin
      m_acc = mem_valid && (q.size() < 2);
      m_ret = (q.size() > 0) && wb_ready;
      if (flush) begin
        q.delete();
        zero_known = 1'b0;
      end else begin
        if (m_ret) void'(q.pop_front());
        if (m_acc) begin
          q.push_back(bun_t'{mem_wdata, mem_wd, mem_wreg});
          zero_known = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_v = (q.size() > 0);
    chk("wb_valid",      {63'd0, wb_valid},    {63'd0, exp_v});
    chk("mem_ready",     {63'd0, mem_ready},   {63'd0, q.size() < 2});
    chk("skid_full",     {63'd0, skid_full},   {63'd0, q.size() == 2});
    chk("wb_valid_n",    {63'd0, wb_valid_n},  {63'd0, exp_v});
    chk("mem_ready_n",   {63'd0, mem_ready_n}, {63'd0, q.size() < 2});
    chk("skid_full_n",   {63'd0, skid_full_n}, {63'd0, q.size() == 2});
    if (exp_v) begin
      chk("wb_wdata",    wb_wdata,             q[0].wdata);
      chk("wb_wd",       {54'd0, wb_wd},       {54'd0, q[0].wd});
      chk("wb_wreg",     {62'd0, wb_wreg},     {62'd0, exp_wreg(q[0], 1'b1)});
      chk("wb_wdata_n",  wb_wdata_n,           q[0].wdata);
      chk("wb_wd_n",     {54'd0, wb_wd_n},     {54'd0, q[0].wd});
      chk("wb_wreg_n",   {62'd0, wb_wreg_n},   {62'd0, exp_wreg(q[0], 1'b0)});
    end else begin
      chk("wb_wreg_idle",   {62'd0, wb_wreg},   64'd0);
      chk("wb_wreg_n_idle", {62'd0, wb_wreg_n}, 64'd0);
      if (zero_known) begin
        chk("wb_wdata_rst", wb_wdata,         64'd0);
        chk("wb_wd_rst",    {54'd0, wb_wd},   64'd0);
        chk("wb_wdata_n_rst", wb_wdata_n,     64'd0);
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] we,
                       input bit rdy, input bit fl);
    mem_valid = v;
    mem_wdata = {d1, d0};
    mem_wd    = {a1, a0};
    mem_wreg  = we;
    wb_ready  = rdy;
    flush     = fl;
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 2'b00, rdy, 1'b0);
  endtask

  task automatic push(input logic [31:0] d, input bit rdy);
    drive(1'b1, d, d + 32'h100, 5'd1, 5'd2, 2'b11, rdy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    wb_ready = 1'b0;
    mem_valid = 1'b1;
    mem_wdata = 64'hDEAD_BEEF_1234_5678;
    mem_wd = 10'h3FF;
    mem_wreg = 2'b11;
    @(negedge clk);
    chk("rst_wb_valid",  {63'd0, wb_valid},  64'd0);
    chk("rst_wb_wreg",   {62'd0, wb_wreg},   64'd0);
    chk("rst_mem_ready", {63'd0, mem_ready}, 64'd1);
    chk("rst_wb_wdata",  wb_wdata,           64'd0);
    chk("rst_wb_wd",     {54'd0, wb_wd},     64'd0);
    mem_valid = 1'b0;
    rst = 1'b0;
    idle(1'b1);

    // streaming
    push(32'h11, 1'b1);
    chk("stream_11", wb_wdata, 64'h0000_0111_0000_0011);
    chk("stream_skid", {63'd0, skid_full}, 64'd0);
    push(32'h22, 1'b1);
    chk("stream_22", wb_wdata, 64'h0000_0122_0000_0022);
    push(32'h33, 1'b1);
    chk("stream_33", wb_wdata, 64'h0000_0133_0000_0033);
    chk("stream_skid2", {63'd0, skid_full}, 64'd0);
    chk("stream_wreg", {62'd0, wb_wreg}, 64'd3);
    idle(1'b1);
    chk("stream_drained", {63'd0, wb_valid}, 64'd0);

    // back-pressure through the skid entry
    push(32'hA, 1'b0);
    chk("bp_A", wb_wdata[31:0], 64'hA);
    push(32'hB, 1'b0);
    chk("bp_full", {63'd0, skid_full}, 64'd1);
    chk("bp_not_ready", {63'd0, mem_ready}, 64'd0);
    push(32'hC, 1'b0);
    chk("bp_hold_A", wb_wdata[31:0], 64'hA);
    push(32'hC, 1'b1);
    chk("bp_B", wb_wdata[31:0], 64'hB);
    chk("bp_ready_again", {63'd0, mem_ready}, 64'd1);
    push(32'hC, 1'b1);
    chk("bp_C", wb_wdata[31:0], 64'hC);
    chk("bp_C_valid", {63'd0, wb_valid}, 64'd1);
    idle(1'b1);
    chk("bp_drained", {63'd0, wb_valid}, 64'd0);

    // flush while full, with D offered
    push(32'hE, 1'b0);
    push(32'hF, 1'b0);
    chk("fl_full", {63'd0, skid_full}, 64'd1);
    drive(1'b1, 32'hD, 32'hD, 5'd3, 5'd4, 2'b11, 1'b0, 1'b1);
    chk("fl_valid", {63'd0, wb_valid}, 64'd0);
    chk("fl_skid", {63'd0, skid_full}, 64'd0);
    chk("fl_ready", {63'd0, mem_ready}, 64'd1);
    idle(1'b1);
    chk("fl_no_D", {63'd0, wb_valid}, 64'd0);

    // r0 squashing, and equal destinations passed through
    drive(1'b1, 32'h5, 32'h6, 5'd0, 5'd7, 2'b11, 1'b1, 1'b0);
    chk("sq_on",  {62'd0, wb_wreg},   64'h2);
    chk("sq_off", {62'd0, wb_wreg_n}, 64'h3);
    chk("sq_wd",  {54'd0, wb_wd},     64'h0E0);
    drive(1'b1, 32'h8, 32'h9, 5'd3, 5'd3, 2'b11, 1'b1, 1'b0);
    chk("same_wd_wreg", {62'd0, wb_wreg}, 64'h3);
    chk("same_wd",      {54'd0, wb_wd},   64'h063);
    idle(1'b1);

    // mixed traffic, checked by the model
    for (int i = 0; i < 80; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    idle(1'b1);
    idle(1'b1);

    // async reset while full
    push(32'h61, 1'b0);
    push(32'h62, 1'b0);
    chk("ar_full", {63'd0, skid_full}, 64'd1);
    mem_valid = 1'b0;
    wb_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("ar_valid",  {63'd0, wb_valid},  64'd0);
    chk("ar_skid",   {63'd0, skid_full}, 64'd0);
    chk("ar_wdata",  wb_wdata,           64'd0);
    chk("ar_wreg",   {62'd0, wb_wreg},   64'd0);
    #1 rst = 1'b0;
    #1;
    chk("ar_ready_noclk", {63'd0, mem_ready}, 64'd1);
    @(negedge clk);
    idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
